// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-granular main-memory port between the I-cache and D-cache.
// All outputs are registered; one transaction in flight at a time, with no preemption.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  grant_i_cnt,
    output logic [CNT_W-1:0]  grant_d_cnt
);

    typedef enum logic [1:0] {StIdle, StGntI, StGntD, StDone} state_e;

    state_e              state_q, state_d;
    logic                last_d_q, last_d_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                i_ready_q, i_ready_d;
    logic                d_ready_q, d_ready_d;
    logic [CNT_W-1:0]    grant_i_cnt_q, grant_i_cnt_d;
    logic [CNT_W-1:0]    grant_d_cnt_q, grant_d_cnt_d;
    logic                i_req, d_req, pick_d;

    always_comb begin
        state_d       = state_q;
        last_d_d      = last_d_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        i_rdata_d     = i_rdata_q;
        d_rdata_d     = d_rdata_q;
        i_ready_d     = 1'b0;
        d_ready_d     = 1'b0;
        grant_i_cnt_d = grant_i_cnt_q;
        grant_d_cnt_d = grant_d_cnt_q;
        i_req         = i_read;
        d_req         = d_read | d_write;
        // On a tie, the side that did not win last time gets the port.
        pick_d        = d_req & (~i_req | ~last_d_q);

        unique case (state_q)
            StIdle: begin
                if (pick_d) begin
                    mem_addr_d    = d_addr;
                    mem_wdata_d   = d_wdata;
                    mem_write_d   = d_write;
                    mem_read_d    = ~d_write;
                    last_d_d      = 1'b1;
                    grant_d_cnt_d = grant_d_cnt_q + CNT_W'(1);
                    state_d       = StGntD;
                end else if (i_req) begin
                    mem_addr_d    = i_addr;
                    mem_read_d    = 1'b1;
                    mem_write_d   = 1'b0;
                    last_d_d      = 1'b0;
                    grant_i_cnt_d = grant_i_cnt_q + CNT_W'(1);
                    state_d       = StGntI;
                end
            end
            StGntI: begin
                if (mem_ready) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    i_rdata_d   = mem_rdata;
                    i_ready_d   = 1'b1;
                    state_d     = StDone;
                end
            end
            StGntD: begin
                if (mem_ready) begin
                    // Write-backs leave the previously returned D line untouched.
                    if (mem_read_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    d_ready_d   = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            last_d_q      <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            i_rdata_q     <= '0;
            d_rdata_q     <= '0;
            i_ready_q     <= 1'b0;
            d_ready_q     <= 1'b0;
            grant_i_cnt_q <= '0;
            grant_d_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            last_d_q      <= last_d_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            i_rdata_q     <= i_rdata_d;
            d_rdata_q     <= d_rdata_d;
            i_ready_q     <= i_ready_d;
            d_ready_q     <= d_ready_d;
            grant_i_cnt_q <= grant_i_cnt_d;
            grant_d_cnt_q <= grant_d_cnt_d;
        end
    end

    assign i_rdata     = i_rdata_q;
    assign i_ready     = i_ready_q;
    assign d_rdata     = d_rdata_q;
    assign d_ready     = d_ready_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign busy        = (state_q != StIdle);
    assign grant_i_cnt = grant_i_cnt_q;
    assign grant_d_cnt = grant_d_cnt_q;

endmodule
